// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a parameterised UART transmitter (start, 5..8 data bits LSB first,
// optional parity, 1..2 stop bits). The serial line is registered one cycle behind the FSM.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_wr,
    output logic                        uart_tx,
    output logic                        busy_tx,
    output logic                        full_tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int   DIV = CLK_HZ / BAUD;
    localparam int   CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   PW  = $clog2(FIFO_DEPTH);
    localparam int   FW  = PW + 1;
    localparam int   BW  = $clog2(DATA_BITS);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 uart_tx_q;
    logic                 busy_q, busy_d;
    logic                 overflow_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]        count_q, count_d;
    logic                 full, push, pop, tick, frame_done, idle_d;
    logic [DATA_BITS-1:0] head_data;

    assign full       = (count_q == FW'(FIFO_DEPTH));
    assign push       = data_in_wr && !full;
    assign tick       = (baud_q == CW'(DIV - 1));
    assign frame_done = (state_q == STOP) && tick && (bit_q == BW'(STOP_BITS - 1));
    // The FIFO head is taken when idle or on the last clock of the final stop bit,
    // which gives back-to-back frames with no idle gap.
    assign pop        = (count_q != '0) && ((state_q == IDLE) || frame_done);
    assign idle_d     = (count_q == '0) && ((state_q == IDLE) || frame_done);
    assign head_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + FW'(1);
        end else if (!push && pop) begin
            count_d = count_q - FW'(1);
        end
        busy_d = !idle_d || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= data_in[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q    <= count_d;
            busy_q     <= busy_d;
            overflow_q <= data_in_wr && full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            uart_tx_q <= 1'b1;
        end else begin
            case (state_q)
                START:   uart_tx_q <= 1'b0;
                DATA:    uart_tx_q <= shift_q[0];
                PAR:     uart_tx_q <= parity_q;
                default: uart_tx_q <= 1'b1;
            endcase
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop) begin
                        shift_q  <= head_data;
                        parity_q <= (^head_data) ^ ODD;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                PAR: begin
                    if (tick) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        baud_q <= '0;
                        if (bit_q == BW'(STOP_BITS - 1)) begin
                            bit_q <= '0;
                            if (pop) begin
                                shift_q  <= head_data;
                                parity_q <= (^head_data) ^ ODD;
                                state_q  <= START;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_tx    = uart_tx_q;
    assign busy_tx    = busy_q;
    assign full_tx    = full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats share one stimulus stream and are checked
// every cycle against a queue/timeline model, plus literal line-level expectations.
module tb_uart_tx_fifo;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = 10;
    localparam int FDEP   = 4;

    logic       clk;
    logic       reset;
    logic [7:0] dataIn;
    logic       dataInWr;
    logic       uartTx [3];
    logic       busyTx [3];
    logic       fullTx [3];
    logic [2:0] fifoCnt [3];
    logic       ovf [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int baseEdge = 0;
    bit ready = 0;

    int fq [3][FDEP];
    int fh [3];
    int fs [3];
    int left [3];
    bit lv [3][128];
    bit expUart [3];
    bit expBusy [3];
    bit expFull [3];
    bit expOvf [3];
    int expCnt [3];

    bit expA [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit exp03 [3] = '{1'b1, 1'b1, 1'b0};

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(FDEP)) dut0 (
        .clk(clk), .reset(reset), .data_in(dataIn), .data_in_wr(dataInWr),
        .uart_tx(uartTx[0]), .busy_tx(busyTx[0]), .full_tx(fullTx[0]),
        .fifo_count(fifoCnt[0]), .overflow(ovf[0]));

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                   .FIFO_DEPTH(FDEP)) dut1 (
        .clk(clk), .reset(reset), .data_in(dataIn), .data_in_wr(dataInWr),
        .uart_tx(uartTx[1]), .busy_tx(busyTx[1]), .full_tx(fullTx[1]),
        .fifo_count(fifoCnt[1]), .overflow(ovf[1]));

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                   .FIFO_DEPTH(FDEP)) dut2 (
        .clk(clk), .reset(reset), .data_in(dataIn), .data_in_wr(dataInWr),
        .uart_tx(uartTx[2]), .busy_tx(busyTx[2]), .full_tx(fullTx[2]),
        .fifo_count(fifoCnt[2]), .overflow(ovf[2]));

    function automatic int dbOf(input int i);
        return (i == 1) ? 7 : 8;
    endfunction

    function automatic int parOf(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int sbOf(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int frameLen(input int i);
        return DIV * (1 + dbOf(i) + ((parOf(i) != 0) ? 1 : 0) + sbOf(i));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Expands one byte into the per-clock line levels of a whole frame.
    task automatic buildFrame(input int i, input int b);
        int p;
        bit pb;
        bit d;
        p = 0;
        pb = 1'b0;
        for (int r = 0; r < DIV; r++) begin
            lv[i][p] = 1'b0;
            p++;
        end
        for (int k = 0; k < dbOf(i); k++) begin
            d = b[k];
            pb = pb ^ d;
            for (int r = 0; r < DIV; r++) begin
                lv[i][p] = d;
                p++;
            end
        end
        if (parOf(i) != 0) begin
            for (int r = 0; r < DIV; r++) begin
                lv[i][p] = (parOf(i) == 1) ? pb : !pb;
                p++;
            end
        end
        for (int r = 0; r < DIV * sbOf(i); r++) begin
            lv[i][p] = 1'b1;
            p++;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            bit wasFull;
            bit level;
            int fl;
            if (reset) begin
                fh[i] = 0;
                fs[i] = 0;
                left[i] = 0;
                expUart[i] = 1'b1;
                expBusy[i] = 1'b0;
                expFull[i] = 1'b0;
                expOvf[i] = 1'b0;
                expCnt[i] = 0;
            end else begin
                fl = frameLen(i);
                wasFull = (fs[i] == FDEP);
                expOvf[i] = dataInWr && wasFull;
                level = (left[i] > 0) ? lv[i][fl - left[i]] : 1'b1;
                if (fs[i] > 0 && left[i] <= 1) begin
                    buildFrame(i, fq[i][fh[i]]);
                    fh[i] = (fh[i] + 1) % FDEP;
                    fs[i]--;
                    left[i] = fl;
                end else if (left[i] > 0) begin
                    left[i]--;
                end
                if (dataInWr && !wasFull) begin
                    fq[i][(fh[i] + fs[i]) % FDEP] = int'(dataIn) & ((1 << dbOf(i)) - 1);
                    fs[i]++;
                end
                expUart[i] = level;
                expCnt[i] = fs[i];
                expFull[i] = (fs[i] == FDEP);
                expBusy[i] = (left[i] > 0) || (fs[i] > 0);
            end
        end
        if (reset) begin
            ready = 1'b1;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ready) begin
                for (int i = 0; i < 3; i++) begin
                    checkOutput($sformatf("inst%0d uart_tx", i), int'(uartTx[i]), int'(expUart[i]));
                    checkOutput($sformatf("inst%0d busy_tx", i), int'(busyTx[i]), int'(expBusy[i]));
                    checkOutput($sformatf("inst%0d full_tx", i), int'(fullTx[i]), int'(expFull[i]));
                    checkOutput($sformatf("inst%0d fifo_count", i), int'(fifoCnt[i]), expCnt[i]);
                    checkOutput($sformatf("inst%0d overflow", i), int'(ovf[i]), int'(expOvf[i]));
                end
            end
        end
    end

    // Writes nBytes consecutive values; baseEdge is the clock edge that takes the first one.
    task automatic applyStimulus(input int nBytes, input logic [7:0] firstByte);
        @(negedge clk);
        for (int k = 0; k < nBytes; k++) begin
            dataIn = firstByte + 8'(k);
            dataInWr = 1'b1;
            if (k == 0) begin
                baseEdge = cyc + 1;
            end
            @(negedge clk);
        end
        dataInWr = 1'b0;
    endtask

    task automatic atEdge(input int k);
        while (cyc < baseEdge + k) begin
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while ((busyTx[0] || busyTx[1] || busyTx[2]) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain within cycle budget", (n < limit) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        dataIn = 8'h00;
        dataInWr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset uart_tx", int'(uartTx[0]), 1);
        checkOutput("reset busy_tx", int'(busyTx[0]), 0);
        checkOutput("reset fifo_count", int'(fifoCnt[0]), 0);
        checkOutput("reset full_tx", int'(fullTx[0]), 0);
        checkOutput("reset overflow", int'(ovf[0]), 0);

        applyStimulus(1, 8'hA5);
        atEdge(1);
        checkOutput("A5 line before start", int'(uartTx[0]), 1);
        atEdge(2);
        checkOutput("A5 start first clock", int'(uartTx[0]), 0);
        atEdge(7);
        checkOutput("A5 start mid", int'(uartTx[0]), 0);
        for (int k = 0; k < 8; k++) begin
            atEdge(17 + 10 * k);
            checkOutput($sformatf("A5 data bit %0d", k), int'(uartTx[0]), int'(expA[k]));
        end
        atEdge(87);
        checkOutput("A5 7O2 parity", int'(uartTx[1]), 0);
        atEdge(97);
        checkOutput("A5 8N1 stop", int'(uartTx[0]), 1);
        checkOutput("A5 8E1 parity", int'(uartTx[2]), 0);
        atEdge(100);
        checkOutput("A5 busy at last frame clock", int'(busyTx[0]), 1);
        atEdge(101);
        checkOutput("A5 busy after 100 clocks", int'(busyTx[0]), 0);
        atEdge(111);
        checkOutput("A5 7O2 busy after 110", int'(busyTx[1]), 0);
        waitIdle(300);

        applyStimulus(1, 8'h03);
        for (int k = 0; k < 3; k++) begin
            atEdge(17 + 10 * k);
            checkOutput($sformatf("03 7O2 data bit %0d", k), int'(uartTx[1]), int'(exp03[k]));
        end
        atEdge(87);
        checkOutput("03 7O2 parity", int'(uartTx[1]), 1);
        atEdge(97);
        checkOutput("03 7O2 stop 1", int'(uartTx[1]), 1);
        checkOutput("03 8E1 parity", int'(uartTx[2]), 0);
        atEdge(107);
        checkOutput("03 7O2 stop 2", int'(uartTx[1]), 1);
        atEdge(110);
        checkOutput("03 7O2 busy at 110", int'(busyTx[1]), 1);
        atEdge(111);
        checkOutput("03 7O2 busy after 110", int'(busyTx[1]), 0);
        waitIdle(300);

        applyStimulus(1, 8'h07);
        atEdge(97);
        checkOutput("07 8E1 parity", int'(uartTx[2]), 1);
        waitIdle(300);

        applyStimulus(6, 8'h11);
        checkOutput("burst overflow pulse", int'(ovf[0]), 1);
        checkOutput("burst full_tx", int'(fullTx[0]), 1);
        checkOutput("burst fifo_count", int'(fifoCnt[0]), 4);
        atEdge(6);
        checkOutput("burst overflow one cycle", int'(ovf[0]), 0);
        atEdge(101);
        checkOutput("burst frame1 stop", int'(uartTx[0]), 1);
        atEdge(102);
        checkOutput("burst frame2 start no gap", int'(uartTx[0]), 0);
        atEdge(500);
        checkOutput("burst busy through 5 frames", int'(busyTx[0]), 1);
        atEdge(501);
        checkOutput("burst busy after 5 frames", int'(busyTx[0]), 0);
        waitIdle(1000);

        applyStimulus(5, 8'h21);
        atEdge(100);
        checkOutput("full-pop count before", int'(fifoCnt[0]), 4);
        dataIn = 8'h99;
        dataInWr = 1'b1;
        @(negedge clk);
        dataInWr = 1'b0;
        checkOutput("full-pop count after", int'(fifoCnt[0]), 3);
        checkOutput("full-pop overflow", int'(ovf[0]), 1);
        waitIdle(1000);

        applyStimulus(3, 8'h31);
        atEdge(35);
        checkOutput("pre-reset fifo_count", int'(fifoCnt[0]), 2);
        reset = 1'b1;
        dataIn = 8'hFF;
        dataInWr = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dataInWr = 1'b0;
        checkOutput("mid-frame reset uart_tx", int'(uartTx[0]), 1);
        checkOutput("mid-frame reset fifo_count", int'(fifoCnt[0]), 0);
        checkOutput("mid-frame reset busy_tx", int'(busyTx[0]), 0);
        atEdge(96);
        checkOutput("after reset line idle", int'(uartTx[0]), 1);
        checkOutput("after reset still idle", int'(busyTx[0]), 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate; bit period DIV = CLK_HZ/BAUD (integer truncation), DIV >= 2.
REQ-003 Parameter DATA_BITS, default 8, legal 5..8, data bits per frame, LSB first.
REQ-004 Parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal 1..2.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two, 2..16.
REQ-007 clk  input  1  single clock; one clock, reset is synchronous and active-high.
REQ-008 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-009 data_in  input  8  byte to queue; bits above DATA_BITS-1 ignored.
REQ-010 data_in_wr  input  1  write strobe, level-sampled, one byte per high cycle.
REQ-011 uart_tx  output  1  registered serial line, idle high.
REQ-012 busy_tx  output  1  high while FIFO non-empty or a frame is in progress.
REQ-013 full_tx  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-016 The write SHALL be accepted on each rising clk with data_in_wr=1 and full_tx=0; count increments next cycle.
REQ-017 A write with full_tx=1 SHALL be dropped and SHALL pulse overflow the following cycle, even if a pop occurs in that same cycle.
REQ-018 Simultaneous accepted write and pop SHALL leave fifo_count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-020 IDLE -> START when FIFO non-empty; head entry popped into the shift register at that transition.
REQ-021 Each of START, every DATA bit, PAR, and every STOP bit SHALL drive uart_tx for exactly DIV clocks.
REQ-022 Line levels: START = 0; DATA = shift-register LSB first, DATA_BITS bits; PAR = XOR of data bits (even) or its inverse (odd); STOP = 1.
REQ-023 PAR SHALL be skipped when PARITY=0 (DATA -> STOP directly).
REQ-024 STOP SHALL last STOP_BITS*DIV clocks; then START if FIFO non-empty (back-to-back, no idle gap), else IDLE.
REQ-025 Latency: write accepted at edge N into empty FIFO with FSM IDLE -> uart_tx first low after edge N+2.
REQ-026 busy_tx SHALL be registered and fall in the same cycle the FSM enters IDLE with FIFO empty.
REQ-027 uart_tx SHALL be driven from a flop only (glitch-free); IDLE drives 1.

Reset
REQ-028 On reset, next cycle: uart_tx=1, busy_tx=0, full_tx=0, fifo_count=0, overflow=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately and discard all queued bytes; writes during reset are ignored.

Verification (CLK_HZ=1000000, BAUD=100000 -> DIV=10)
REQ-030 8N1, write 0xA5 at idle -> uart_tx low from edge N+2 for 10 clocks, then 1,0,1,0,0,1,0,1 each 10 clocks, high 10 clocks, busy_tx low after 100 clocks.
REQ-031 DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x03 -> start, 1,1,0,0,0,0,0, parity 1, two stop bits; frame 110 clocks.
REQ-032 FIFO_DEPTH=4, write 6 bytes on consecutive cycles -> bytes 1-5 accepted (first is popped within 1 cycle), byte 6 dropped, overflow one pulse, full_tx high; 5 frames back-to-back with no idle gap.
REQ-033 Write while FIFO full in same cycle as pop -> write dropped, fifo_count decrements by 1, overflow pulses.
REQ-034 Assert reset 35 clocks into an 8N1 frame with 2 bytes queued -> uart_tx=1 and fifo_count=0 next cycle; no further frame until new write.
REQ-035 PARITY=1, write 0x07 (8 bits) -> parity bit 1; write 0x03 -> parity bit 0.
